// File: rtl/riscv32i_fetch_pkg.sv
// Shared types and constants for the riscv32i instruction fetch stage.
package riscv32i_fetch_pkg;

  // Fetch control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the PC it was read from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [31:0] PC_STEP     = 32'd4;

  // True when the word is the EBREAK instruction used as the simulation stop marker
  function automatic logic is_ebreak(input logic [31:0] instr);
    return (instr == EBREAK_INSN);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} entries between the BRAM and decode.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
  import riscv32i_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop  && !i_flush;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/riscv32i_fetch.sv
// Instruction fetch stage: issues BRAM word reads, buffers responses with their
// PCs and streams them to decode. Handles redirects, halt/resume and EBREAK stop.
//
// Handshake: an entry transfers to decode at a rising edge where
// fetch_valid && dec_ready. fetch_valid never depends on dec_ready, and while
// dec_ready=0 the head entry (fetch_pc / fetch_instruction) is held unchanged.
module riscv32i_fetch
  import riscv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instruction,
  output logic        stop_sim,
  output logic        ins_mem_enb,
  output logic [31:0] ins_mem_addrb,
  output logic [3:0]  ins_mem_web,
  input  logic [31:0] ins_mem_doutb,
  output logic [1:0]  dbg_state
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_inflight_pc;
  logic             r_inflight;
  logic             r_stop_sim;

  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic [CNT_W-1:0] w_count;
  logic             w_valid;
  logic             w_pop;
  logic             w_ebreak_pop;
  logic             w_flush;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ;

  assign w_valid      = (w_count != '0);
  assign w_pop        = w_valid && dec_ready;
  // A redirect in the same cycle discards the whole buffer, EBREAK included
  assign w_ebreak_pop = w_pop && !redirect_valid && is_ebreak(w_head.instr);
  assign w_flush      = redirect_valid || w_ebreak_pop;
  assign w_push       = r_inflight && !w_flush;

  // Occupancy the buffer will have after this cycle's pop, counting the read
  // in flight. Counting the pop lets a full-rate stream keep one read going
  // every cycle while guaranteeing a response never lands in a full FIFO.
  assign w_occ   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue = (r_state == RUN) && !w_flush && (w_occ < DEPTH_OCC);

  assign w_push_data.pc    = r_inflight_pc;
  assign w_push_data.instr = ins_mem_doutb;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: redirect freezes state, EBREAK pop forces HALT, halt beats start
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = r_state;
    end else if (w_ebreak_pop) begin
      w_state_next = HALT;
    end else begin
      case (r_state)
        IDLE:    if (start && !halt) w_state_next = RUN;
        RUN:     if (halt) w_state_next = HALT;
        HALT:    if (start && !halt && !r_stop_sim) w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Fetch PC: redirect target is word aligned, otherwise advance on each issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_pc[31:2], 2'b00};
    else if (w_issue)        r_pc <= r_pc + PC_STEP;
  end

  // In-flight read tracking; a flush cycle never issues, so the old response is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
    end
  end

  // Sticky stop flag raised when decode consumes EBREAK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_stop_sim <= 1'b0;
    else if (w_ebreak_pop) r_stop_sim <= 1'b1;
  end

  assign fetch_valid       = w_valid;
  assign fetch_pc          = w_valid ? w_head.pc    : 32'h0;
  assign fetch_instruction = w_valid ? w_head.instr : 32'h0;
  assign stop_sim          = r_stop_sim;
  assign ins_mem_enb       = w_issue;
  assign ins_mem_addrb     = r_pc;
  assign ins_mem_web       = 4'b0000;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_riscv32i_fetch.sv
// Directed bench for riscv32i_fetch with a BRAM model and a scoreboard that
// checks every entry decode accepts against an expected queue.
module tb_riscv32i_fetch;
  import riscv32i_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        stop_sim;
  logic        ins_mem_enb;
  logic [31:0] ins_mem_addrb;
  logic [3:0]  ins_mem_web;
  logic [31:0] ins_mem_doutb;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] bram [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  riscv32i_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .halt              (halt),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dec_ready         (dec_ready),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .stop_sim          (stop_sim),
    .ins_mem_enb       (ins_mem_enb),
    .ins_mem_addrb     (ins_mem_addrb),
    .ins_mem_web       (ins_mem_web),
    .ins_mem_doutb     (ins_mem_doutb),
    .dbg_state         (dbg_state)
  );

  // BRAM port B model: one-cycle registered read
  always @(posedge clk) begin
    if (ins_mem_enb) ins_mem_doutb <= bram[ins_mem_addrb[9:2]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h13 + ({24'h0, pc[9:2]} << 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic expect_run(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) expect_entry(pc0 + 32'(4 * i), word_at(pc0 + 32'(4 * i)));
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    exp_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && fetch_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%08h instr 0x%08h, expected no entry",
                 fetch_pc, fetch_instruction);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", fetch_pc, e[63:32]);
        check("pop_instr", fetch_instruction, e[31:0]);
      end
      n_pops++;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int waited;
    for (int i = 0; i < 256; i++) bram[i] = word_at(32'(i * 4));
    rst_n          = 1'b0;
    start          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_instr", fetch_instruction, 32'h0);
    check("rst_stop", 32'(stop_sim), 32'd0);
    check("rst_enb", 32'(ins_mem_enb), 32'd0);
    check("rst_addr", ins_mem_addrb, 32'h0);
    check("rst_web", 32'(ins_mem_web), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    cyc();

    // Start-up latency and back-to-back stream
    expect_run(32'h0, 40);
    dec_ready = 1'b1;
    pulse_start();                                      // E0
    check("start_state", 32'(dbg_state), 32'(RUN));
    check("start_enb", 32'(ins_mem_enb), 32'd1);
    check("start_addr", ins_mem_addrb, 32'h0);
    cyc();                                              // E1
    check("e1_valid", 32'(fetch_valid), 32'd0);
    check("e1_addr", ins_mem_addrb, 32'h4);
    cyc();                                              // E2
    check("e2_valid", 32'(fetch_valid), 32'd1);
    check("e2_pc", fetch_pc, 32'h0);
    check("e2_instr", fetch_instruction, 32'h13);
    cyc();                                              // E3
    check("e3_pc", fetch_pc, 32'h4);
    check("e3_instr", fetch_instruction, 32'h93);
    cyc();                                              // E4
    check("e4_pc", fetch_pc, 32'h8);

    // Decode stall: head frozen, issue stops with two entries outstanding
    dec_ready = 1'b0;
    #1;
    check("stall_enb", 32'(ins_mem_enb), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", 32'(fetch_valid), 32'd1);
      check("stall_pc", fetch_pc, 32'h8);
      check("stall_instr", fetch_instruction, word_at(32'h8));
      check("stall_enb", 32'(ins_mem_enb), 32'd0);
    end
    dec_ready = 1'b1;
    repeat (4) cyc();

    // Halt, drain, resume ten cycles later
    pulse_halt();
    check("halt_state", 32'(dbg_state), 32'(HALT));
    check("halt_enb", 32'(ins_mem_enb), 32'd0);
    repeat (9) cyc();
    check("halt_drained", 32'(fetch_valid), 32'd0);
    p0 = n_pops;
    pulse_start();
    check("resume_state", 32'(dbg_state), 32'(RUN));
    repeat (6) cyc();
    check("resume_progress", 32'(n_pops - p0 >= 3), 32'd1);

    // start together with halt keeps HALT
    pulse_halt();
    repeat (6) cyc();
    start = 1'b1;
    halt  = 1'b1;
    cyc();
    start = 1'b0;
    halt  = 1'b0;
    check("start_halt_state", 32'(dbg_state), 32'(HALT));
    repeat (3) cyc();
    check("start_halt_valid", 32'(fetch_valid), 32'd0);
    check("start_halt_enb", 32'(ins_mem_enb), 32'd0);

    // Redirect with FIFO holding PC 4 and PC 8 in flight
    do_reset();
    expect_run(32'h0, 1);
    dec_ready = 1'b1;
    pulse_start();                                      // E0
    cyc();                                              // E1
    cyc();                                              // E2
    check("redir_e2_pc", fetch_pc, 32'h0);
    cyc();                                              // E3
    check("redir_head_pc", fetch_pc, 32'h4);
    dec_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    exp_q.delete();
    expect_run(32'h100, 16);
    #1;
    check("redir_no_issue", 32'(ins_mem_enb), 32'd0);
    cyc();                                              // R+1
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    #1;
    check("redir_flushed", 32'(fetch_valid), 32'd0);
    check("redir_enb", 32'(ins_mem_enb), 32'd1);
    check("redir_addr", ins_mem_addrb, 32'h100);
    cyc();                                              // R+2
    check("redir_r2_valid", 32'(fetch_valid), 32'd0);
    cyc();                                              // R+3
    check("redir_r3_valid", 32'(fetch_valid), 32'd1);
    check("redir_r3_pc", fetch_pc, 32'h100);
    repeat (4) cyc();

    // Reset asserted mid-stream
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(fetch_valid), 32'd0);
    check("mid_rst_pc", fetch_pc, 32'h0);
    check("mid_rst_instr", fetch_instruction, 32'h0);
    check("mid_rst_enb", 32'(ins_mem_enb), 32'd0);
    check("mid_rst_addr", ins_mem_addrb, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    check("post_rst_addr", ins_mem_addrb, 32'h0);

    // EBREAK at PC 0xC stops the stream
    bram[3] = EBREAK_INSN;
    do_reset();
    expect_run(32'h0, 3);
    expect_entry(32'hC, EBREAK_INSN);
    dec_ready = 1'b1;
    pulse_start();
    waited = 0;
    while (!stop_sim && waited < 20) begin
      cyc();
      waited++;
    end
    check("ebreak_stop", 32'(stop_sim), 32'd1);
    check("ebreak_valid", 32'(fetch_valid), 32'd0);
    check("ebreak_state", 32'(dbg_state), 32'(HALT));
    check("ebreak_all_popped", 32'(exp_q.size()), 32'd0);
    repeat (3) cyc();
    pulse_start();
    check("ebreak_start_ignored", 32'(dbg_state), 32'(HALT));
    repeat (4) cyc();
    check("ebreak_quiet_valid", 32'(fetch_valid), 32'd0);
    check("ebreak_quiet_enb", 32'(ins_mem_enb), 32'd0);
    check("ebreak_sticky", 32'(stop_sim), 32'd1);

    // Redirect while IDLE to the last word, then PC wraps to zero
    bram[3] = word_at(32'hC);
    do_reset();
    check("wrap_rst_stop", 32'(stop_sim), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFD;
    cyc();
    redirect_valid = 1'b0;
    check("wrap_idle_state", 32'(dbg_state), 32'(IDLE));
    check("wrap_idle_addr", ins_mem_addrb, 32'hFFFF_FFFC);
    expect_run(32'hFFFF_FFFC, 12);
    dec_ready = 1'b1;
    pulse_start();                                      // E0
    check("wrap_e0_addr", ins_mem_addrb, 32'hFFFF_FFFC);
    cyc();                                              // E1
    check("wrap_e1_addr", ins_mem_addrb, 32'h0);
    check("wrap_e1_enb", 32'(ins_mem_enb), 32'd1);
    cyc();                                              // E2
    check("wrap_e2_pc", fetch_pc, 32'hFFFF_FFFC);
    check("wrap_e2_instr", fetch_instruction, 32'h7F93);
    repeat (3) cyc();
    pulse_halt();
    repeat (8) cyc();
    check("wrap_drained", 32'(fetch_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
